// File: rtl/fetch_unit_buffered.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests under a credit
// limit, buffers returned words with their PCs, and flushes on redirect.
module fetch_unit_buffered #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and payload is held while valid & !ready.

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] live;
  logic [CW:0]   credit_used;

  logic req_fire;
  logic rsp_keep;
  logic pop;

  // Credits cover both buffered words and live in-flight requests, so a kept
  // response always finds a free slot.
  assign live        = outstanding - drop;
  assign credit_used = {1'b0, count} + {1'b0, live};

  assign imem_req_valid = !reset && !redirect_valid
                          && (credit_used < (CW+1)'(DEPTH))
                          && (outstanding < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when nothing stale is ahead of it and no redirect is flushing.
  assign rsp_keep = !reset && imem_rsp_valid && (drop == '0) && !redirect_valid;

  assign out_valid = !reset && (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (req_fire) tag_wr <= tag_wr + PW'(1);
      if (imem_rsp_valid) tag_rd <= tag_rd + PW'(1);
      if (rsp_keep) wr_ptr <= wr_ptr + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
        // Everything still in flight after this cycle's response is stale.
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= wr_ptr;
        drop     <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(rsp_keep) - CW'(pop);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and counters.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
    if (rsp_keep) begin
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!rsp_keep || (count < CW'(DEPTH)));
      assert (!imem_rsp_valid || (outstanding != '0));
    end
  end

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Directed bench for fetch_unit_buffered: in-order memory model with configurable latency,
// per-cycle vector table for streaming, hand sequences for stall, redirect and reset cases.
module tb_fetch_unit_buffered;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  fetch_unit_buffered #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0), .PC_STEP(64'h4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int mem_lat = 1;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  logic [63:0] exp_q[$];

  logic        o_req_valid;
  logic        o_req_fire;
  logic [63:0] o_req_addr;
  logic        o_out_valid;
  logic        o_pop;
  logic [63:0] o_out_pc;
  logic [31:0] o_out_instr;

  typedef struct {
    logic        rdy;
    logic        req_v;
    logic [63:0] req_a;
    logic        out_v;
    logic [63:0] out_p;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive the memory response, sample the DUT mid-cycle, score pops,
  // then advance the memory model at the edge.
  task automatic tick();
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    o_req_valid = imem_req_valid;
    o_req_fire  = imem_req_valid && imem_req_ready;
    o_req_addr  = imem_req_addr;
    o_out_valid = out_valid;
    o_pop       = out_valid && out_ready;
    o_out_pc    = out_pc;
    o_out_instr = out_instr;
    if (o_pop) begin
      chk("pop_instr", 64'(o_out_instr), 64'(instr_of(o_out_pc)));
      if (exp_q.size() > 0) chk("pop_pc", o_out_pc, exp_q.pop_front());
      else begin
        n_total++;
        $display("FAIL pop_unexpected: got pc %h expected no pop (cycle %0d)", o_out_pc, cyc);
      end
    end
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (o_req_fire) mq.push_back('{addr: o_req_addr, due: cyc + mem_lat});
    end
    cyc++;
    #1;
  endtask

  task automatic reset_dut(input int lat);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    mem_lat = lat;
    reset   = 1'b0;
  endtask

  initial begin
    int          fires;
    logic [63:0] addrs[$];
    logic [63:0] a;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Reset state; redirect raised alongside reset must be ignored.
    tick();
    chk("rst_req_valid", 64'(o_req_valid), 64'd0);
    chk("rst_out_valid", 64'(o_out_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h500;
    tick();
    chk("rst_redir_req_valid", 64'(o_req_valid), 64'd0);
    redirect_valid = 1'b0;
    reset          = 1'b0;
    mem_lat        = 1;

    // Streaming with a 1-cycle memory: first word visible two cycles after its request.
    tbl[0] = '{1'b1, 1'b1, 64'h00, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 1'b1, 64'h04, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 1'b1, 64'h08, 1'b1, 64'h0};
    tbl[3] = '{1'b1, 1'b1, 64'h0C, 1'b1, 64'h4};
    tbl[4] = '{1'b1, 1'b1, 64'h10, 1'b1, 64'h8};
    tbl[5] = '{1'b1, 1'b1, 64'h14, 1'b1, 64'hC};
    exp_q = '{64'h0, 64'h4, 64'h8, 64'hC};
    for (int i = 0; i < 6; i++) begin
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("t1_req_valid[%0d]", i), 64'(o_req_valid), 64'(tbl[i].req_v));
      chk($sformatf("t1_req_addr[%0d]", i), o_req_addr, tbl[i].req_a);
      chk($sformatf("t1_out_valid[%0d]", i), 64'(o_out_valid), 64'(tbl[i].out_v));
      if (tbl[i].out_v) chk($sformatf("t1_out_pc[%0d]", i), o_out_pc, tbl[i].out_p);
    end
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: exactly DEPTH requests, then one more per popped entry.
    reset_dut(1);
    fires = 0;
    addrs.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_req_fire) begin
        fires++;
        addrs.push_back(o_req_addr);
      end
    end
    chk("t2_fires", 64'(fires), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a = (i < addrs.size()) ? addrs[i] : 64'hDEAD;
      chk($sformatf("t2_addr[%0d]", i), a, 64'(4 * i));
    end
    chk("t2_full_req_valid", 64'(o_req_valid), 64'd0);
    chk("t2_full_out_valid", 64'(o_out_valid), 64'd1);
    chk("t2_hold_pc", o_out_pc, 64'h0);
    chk("t2_hold_instr", 64'(o_out_instr), 64'(instr_of(64'h0)));
    exp_q.push_back(64'h0);
    out_ready = 1'b1;
    tick();
    chk("t2_pop_req_valid", 64'(o_req_valid), 64'd0);
    out_ready = 1'b0;
    fires = 0;
    addrs.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_req_fire) begin
        fires++;
        addrs.push_back(o_req_addr);
      end
    end
    chk("t2_refill_fires", 64'(fires), 64'd1);
    a = (addrs.size() > 0) ? addrs[0] : 64'hDEAD;
    chk("t2_refill_addr", a, 64'h10);
    chk("t2_next_head", o_out_pc, 64'h4);
    chk("t2_refull_req_valid", 64'(o_req_valid), 64'd0);

    // Redirect with three requests in flight on a 3-cycle memory.
    reset_dut(3);
    out_ready = 1'b1;
    exp_q = '{64'h100, 64'h104, 64'h108};
    repeat (3) tick();
    chk("t3_third_req", o_req_addr, 64'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    chk("t3_redir_req_valid", 64'(o_req_valid), 64'd0);
    redirect_valid = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      tick();
      if (k == 4) chk("t3_new_addr", o_req_addr, 64'h100);
      if (k < 8) chk($sformatf("t3_out_valid[%0d]", k), 64'(o_out_valid), 64'd0);
    end
    chk("t3_drain", 64'(exp_q.size()), 64'd0);

    // Redirect coinciding with a pop and a response while two entries are buffered.
    reset_dut(2);
    repeat (4) tick();
    exp_q = '{64'h0, 64'h200, 64'h204};
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    chk("t4_pop_valid", 64'(o_pop), 64'd1);
    chk("t4_redir_req_valid", 64'(o_req_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("t4_empty_after", 64'(o_out_valid), 64'd0);
    chk("t4_new_addr", o_req_addr, 64'h200);
    chk("t4_new_req_valid", 64'(o_req_valid), 64'd1);
    tick();
    chk("t4_no_stale_c6", 64'(o_out_valid), 64'd0);
    tick();
    chk("t4_no_stale_c7", 64'(o_out_valid), 64'd0);
    repeat (2) tick();
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // PC wrap at the top of the address space.
    reset_dut(1);
    out_ready = 1'b1;
    exp_q = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    chk("t5_redir_req_valid", 64'(o_req_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("t5_addr_f8", o_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("t5_addr_fc", o_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t5_addr_wrap", o_req_addr, 64'h0);
    repeat (2) tick();
    chk("t5_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with three entries buffered and one request in flight.
    reset_dut(1);
    repeat (3) tick();
    tick();
    chk("t6_pre_out_valid", 64'(o_out_valid), 64'd1);
    chk("t6_pre_req_addr", o_req_addr, 64'hC);
    reset = 1'b1;
    tick();
    chk("t6_rst_out_valid", 64'(o_out_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(o_req_valid), 64'd0);
    tick();
    chk("t6_rst2_out_valid", 64'(o_out_valid), 64'd0);
    chk("t6_rst2_req_valid", 64'(o_req_valid), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    exp_q     = '{64'h0};
    tick();
    chk("t6_restart_valid", 64'(o_req_valid), 64'd1);
    chk("t6_restart_addr", o_req_addr, 64'h0);
    chk("t6_restart_out_valid", 64'(o_out_valid), 64'd0);
    tick();
    chk("t6_flushed_out_valid", 64'(o_out_valid), 64'd0);
    tick();
    chk("t6_drain", 64'(exp_q.size()), 64'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit_buffered.md
Name: fetch_unit_buffered

Overview:
- Parametrised instruction-fetch front end for the RISC-V datapath.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Stores returned words with their PCs in a DEPTH-entry prefetch buffer and presents them to decode over a valid/ready channel.
- Supports branch/jump redirect, which flushes the buffer and silently discards stale in-flight responses.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction word width.
- DEPTH, 4, prefetch buffer entries and maximum outstanding requests (power of two, ≥2).
- RESET_PC, 0, fetch address after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  XLEN  new fetch address.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response word valid (in request order, ≥1 cycle after acceptance).
- imem_rsp_data  in  ILEN  response word.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  PC of head.
- out_instr  out  ILEN  instruction of head.

Behaviour:
- State:
  - fetch_pc (XLEN).
  - Circular buffer of DEPTH {pc, instr} entries with rd_ptr, wr_ptr and count (0..DEPTH).
  - outstanding (0..DEPTH): requests accepted but not yet responded.
  - drop (0..DEPTH): responses still to be discarded; drop ≤ outstanding.
  - live = outstanding − drop.
- Reset (reset=1 at an edge):
  - fetch_pc=RESET_PC; count=0, pointers=0, outstanding=0, drop=0.
  - imem_req_valid=0 and out_valid=0 combinationally while reset is high.
- Reset mid-operation:
  - Responses to pre-reset requests must not arrive after reset; the memory side is reset together with this block.
- Request issue:
  - imem_req_valid = !reset & !redirect_valid & (count+live < DEPTH) & (outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: outstanding+1, fetch_pc += PC_STEP modulo 2^XLEN (all-ones−3 wraps to 0 with PC_STEP=4).
  - imem_req_valid must not depend on imem_req_ready.
- Response:
  - If drop>0: discard the word; drop−1, outstanding−1.
  - Otherwise: write {pc, data} at wr_ptr; wr_ptr+1 mod DEPTH; count+1; outstanding−1.
  - The credit rule guarantees no overflow; a response to a full buffer is an assertion failure.
- Entry pc tagging:
  - Each request's address is pushed into a DEPTH-deep pc tag queue on issue and popped on response.
  - The tag is written with the instruction, or discarded if the response is dropped.
- Output:
  - out_valid = (count>0) & !reset.
  - out_pc/out_instr = entry at rd_ptr; they must be held stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready: rd_ptr+1, count−1.
- Latency:
  - A response in cycle N is visible on out_* in cycle N+1 (no bypass).
  - With a 1-cycle memory and out_ready=1, steady-state throughput is 1 instr/cycle.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at count=DEPTH−1 and at count=DEPTH (pop only).
- Redirect (redirect_valid=1 at an edge):
  - A pop in the same cycle completes (decode consumed it).
  - All remaining entries are flushed: count=0, rd_ptr=wr_ptr.
  - A response arriving in the same cycle is discarded.
  - drop := outstanding after this cycle's response.
  - fetch_pc := redirect_pc.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Redirect and reset together: reset dominates.

Test Plan:
1. Reset, 1-cycle memory always ready, out_ready=1 → requests to 0x0,0x4,0x8,…; out_pc sequence 0x0,0x4,0x8 with matching words; first out_valid 2 cycles after first request.
2. out_ready=0, DEPTH=4 → exactly 4 requests (0x0–0xC) issued then imem_req_valid=0; count=4; releasing out_ready for one cycle triggers exactly one new request (0x10).
3. 3-cycle memory latency with 3 requests in flight, redirect to 0x100 → the 3 stale responses are dropped; next out_pc=0x100, then 0x104; no stale PC ever appears on out_*.
4. Redirect in the same cycle as a pop and a response, buffer count=2 → popped entry consumed once; buffer empty next cycle; response discarded; drop equals remaining in-flight requests.
5. Redirect to 0xFFFF_FFFF_FFFF_FFF8 → out_pc sequence …FFF8, …FFFC, 0x0.
6. Reset asserted mid-stream with count=3 and outstanding=1 → next cycle out_valid=0, imem_req_valid=0; after release fetch restarts at RESET_PC.
